// File: rtl/pr_fetch_ctrl.sv
// Program-register fetch/sequence controller: opcode/operand fetch, PR strobes, jumps.
// Optional memory-ack watchdog enabled by defining PR_FETCH_TIMEOUT_EN.
module pr_fetch_ctrl #(
  parameter int DATA_W = 8
`ifdef PR_FETCH_TIMEOUT_EN
  , parameter int MEM_TIMEOUT = 15
`endif
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run,
  input  logic              halt_req,
  input  logic [DATA_W-1:0] pr_value,
  output logic              mem_req,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              ar_on_pr,
  output logic              increment_pr,
  output logic [DATA_W-1:0] data_2_pr,
  output logic [DATA_W-1:0] ir_out,
  output logic [DATA_W-1:0] operand_out,
  input  logic              cond_ok,
  output logic              exec_start,
  input  logic              exec_done,
  output logic              busy,
  output logic              halted,
  output logic              fault
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_FETCH,
    S_INC_OP,
    S_OPND,
    S_INC_OPND,
    S_EXEC,
    S_JUMP,
    S_HALT,
    S_FAULT
  } state_t;

  state_t state;
  state_t nxt;
  state_t bnd;

  logic two_byte;
  logic is_jump;
  logic taken;
  logic fire;
  logic in_wait;
  logic tmo;

  assign two_byte = ir_out[DATA_W-1];
  assign is_jump  = ir_out[DATA_W-1 -: 2] == 2'b11;
  assign taken    = ~ir_out[DATA_W-3] | cond_ok;
  // A taken jump spends a second JUMP cycle with the load strobe up.
  assign fire     = (state == S_JUMP) & ~ar_on_pr & taken;
  assign in_wait  = (state == S_FETCH) | (state == S_OPND);

`ifdef PR_FETCH_TIMEOUT_EN
  localparam int CW = $clog2(MEM_TIMEOUT + 1);
  logic [CW-1:0] wait_cnt;

  assign tmo = in_wait & ~mem_ack &
               (wait_cnt == CW'(MEM_TIMEOUT - 1));
`else
  assign tmo   = 1'b0;
  assign fault = 1'b0;
`endif

  always_comb begin
    bnd = S_IDLE;
    if (halt_req)
      bnd = S_HALT;
    else if (run)
      bnd = S_FETCH;
  end

  always_comb begin
    nxt = state;
    unique case (state)
      S_IDLE: begin
        if (halt_req)
          nxt = S_HALT;
        else if (run)
          nxt = S_FETCH;
      end
      S_FETCH: begin
        if (mem_ack)
          nxt = S_INC_OP;
        else if (tmo)
          nxt = S_FAULT;
      end
      S_INC_OP:
        nxt = two_byte ? S_OPND : S_EXEC;
      S_OPND: begin
        if (mem_ack)
          nxt = S_INC_OPND;
        else if (tmo)
          nxt = S_FAULT;
      end
      S_INC_OPND:
        nxt = is_jump ? S_JUMP : S_EXEC;
      S_EXEC: begin
        if (exec_done)
          nxt = bnd;
      end
      S_JUMP: begin
        if (ar_on_pr || !taken)
          nxt = bnd;
      end
      S_HALT:  nxt = S_HALT;
      S_FAULT: nxt = S_FAULT;
      default: nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= S_IDLE;
      mem_req      <= 1'b0;
      increment_pr <= 1'b0;
      ar_on_pr     <= 1'b0;
      exec_start   <= 1'b0;
      busy         <= 1'b0;
      halted       <= 1'b0;
      data_2_pr    <= '0;
      ir_out       <= '0;
      operand_out  <= '0;
`ifdef PR_FETCH_TIMEOUT_EN
      fault        <= 1'b0;
      wait_cnt     <= '0;
`endif
    end else begin
      state        <= nxt;
      mem_req      <= (nxt == S_FETCH) |
                      (nxt == S_OPND);
      increment_pr <= (nxt == S_INC_OP) |
                      (nxt == S_INC_OPND);
      exec_start   <= (nxt == S_EXEC) &
                      (state != S_EXEC);
      ar_on_pr     <= fire;
      busy         <= !(nxt inside
                      {S_IDLE, S_HALT, S_FAULT});
      halted       <= nxt == S_HALT;
      if (state == S_FETCH && mem_ack)
        ir_out <= mem_rdata;
      if (state == S_INC_OP && !two_byte)
        operand_out <= '0;
      if (state == S_OPND && mem_ack)
        operand_out <= mem_rdata;
      if (fire)
        data_2_pr <= operand_out;
`ifdef PR_FETCH_TIMEOUT_EN
      fault <= nxt == S_FAULT;
      if (nxt != state)
        wait_cnt <= '0;
      else if (in_wait)
        wait_cnt <= wait_cnt + 1'b1;
`endif
    end
  end

  a_strobe_excl: assert property (
    @(posedge clk) disable iff (rst)
    !(ar_on_pr && increment_pr));

  a_addr_stable: assert property (
    @(posedge clk) disable iff (rst)
    !(mem_req && (ar_on_pr || increment_pr)));

  a_halt_sticky: assert property (
    @(posedge clk) disable iff (rst)
    halted |=> halted);

endmodule
